// File: rtl/led_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl_if
//
// Command bus between the board control master and the LED sequencer.
// A command transfers on a rising clock edge where cmd_valid and cmd_ready
// are both high.
//
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master command can be accepted this cycle
//   cmd_op     master -> slave  0=NOP, 1=START, 2=PAUSE/RESUME, 3=STOP
//   cmd_mode   master -> slave  0=SHIFT_R, 1=SHIFT_L, 2=BLINK, 3=BOUNCE
//   cmd_div    master -> slave  clocks per step (0 selects the default)
//   cmd_loops  master -> slave  pattern cycles to run (0 = forever)
//
// Parameters:
//   DIV_W   width of cmd_div
//   LOOP_W  width of cmd_loops
// ---------------------------------------------------------------------------
interface led_seq_ctrl_if #(
  parameter int DIV_W  = 18,
  parameter int LOOP_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_mode;
  logic [DIV_W-1:0]  cmd_div;
  logic [LOOP_W-1:0] cmd_loops;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_mode,
    output cmd_div,
    output cmd_loops,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_mode,
    input  cmd_div,
    input  cmd_loops,
    output cmd_ready
  );

endinterface

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//
// Command-driven sequencer for the 8-bit board LED bank. A control master
// issues START / PAUSE / STOP commands over the led_seq_ctrl_if bus. After
// START the block runs a programmable step prescaler and steps through one
// of four display patterns for a programmed number of loops (or forever).
// This block is the only driver of LED.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   cmd        slave modport of led_seq_ctrl_if (valid/ready command bus)
//   LED        out  8-bit LED drive, 1 = lit (registered)
//   busy       out  high while running or paused (registered)
//   done       out  one-cycle pulse when the programmed loops complete
//
// Parameters:
//   DIV_W    width of the step prescaler and cmd_div
//   LOOP_W   width of the loop counter and cmd_loops
//   DEF_DIV  divisor used when cmd_div == 0 (truncated to DIV_W bits)
//
// Build option:
//   LED_SEQ_GAP_EN  when defined, every pattern step is followed by a dark
//                   sub-step of equal length (BLINK excepted).
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter int DIV_W   = 18,
  parameter int LOOP_W  = 8,
  parameter int DEF_DIV = 100000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  led_seq_ctrl_if.slave        cmd,
  output logic [7:0]           LED,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_SHIFT_R = 2'd0,
    MODE_SHIFT_L = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BOUNCE  = 2'd3
  } mode_t;

  // Opcode 0 is a no-op: it is accepted and simply falls through.
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_PAUSE = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [DIV_W-1:0] DEF_DIV_T = DEF_DIV[DIV_W-1:0];

`ifdef LED_SEQ_GAP_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  state_t            state;
  mode_t             mode_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  tick_cnt;
  logic [LOOP_W-1:0] loops_r;
  logic [LOOP_W-1:0] loop_cnt;
  logic [3:0]        step;
  logic              gap_r;

  logic              tick;
  logic              accept;
  logic              gap_active;
  logic [DIV_W-1:0]  start_div;
  mode_t             start_mode;
  logic [3:0]        last_step;
  logic [3:0]        nxt_step;
  logic              nxt_gap;
  logic [7:0]        nxt_led;
  logic              wrap;
  logic [LOOP_W-1:0] loop_nxt;
  logic              complete;

  // LED value shown at step s of the given pattern.
  function automatic logic [7:0] pattern_at(input mode_t m, input logic [3:0] s);
    logic [7:0] p;
    p = 8'h00;
    case (m)
      MODE_SHIFT_R: p = 8'h80 >> s;
      MODE_SHIFT_L: p = 8'h01 << s;
      MODE_BLINK:   p = (s == 4'd0) ? 8'hFF : 8'h00;
      MODE_BOUNCE:  p = (s < 4'd8) ? (8'h80 >> s) : (8'h01 << (s - 4'd7));
      default:      p = 8'h00;
    endcase
    return p;
  endfunction

  // Index of the final step of each pattern's cycle.
  function automatic logic [3:0] last_step_of(input mode_t m);
    logic [3:0] l;
    case (m)
      MODE_BLINK:  l = 4'd1;
      MODE_BOUNCE: l = 4'd13;
      default:     l = 4'd7;
    endcase
    return l;
  endfunction

  // The step tick wins over a pending command, so the bus stalls on
  // tick cycles; the master has to keep the command asserted.
  assign tick          = (state == ST_RUN) && (tick_cnt == (div_r - DIV_W'(1)));
  assign cmd.cmd_ready = ~tick;
  assign accept        = cmd.cmd_valid & ~tick;

  assign start_div  = (cmd.cmd_div == '0) ? DEF_DIV_T : cmd.cmd_div;
  assign start_mode = mode_t'(cmd.cmd_mode);
  assign last_step  = last_step_of(mode_r);

  // BLINK already alternates lit/dark, so it never gets gap sub-steps.
  assign gap_active = GAP_EN && (mode_r != MODE_BLINK);

  // Work out where the next tick takes the sequence. With gaps enabled a
  // lit step first moves to its dark sub-step; the pattern index only
  // advances (and a wrap only counts) when leaving the dark sub-step.
  always_comb begin
    nxt_step = step;
    nxt_gap  = 1'b0;
    nxt_led  = 8'h00;
    wrap     = 1'b0;
    if (gap_active && !gap_r) begin
      nxt_gap = 1'b1;
    end else begin
      wrap     = (step == last_step);
      nxt_step = wrap ? 4'd0 : (step + 4'd1);
      nxt_led  = pattern_at(mode_r, nxt_step);
    end
  end

  // Loop counter saturates so an infinite run never rolls over into a
  // spurious completion.
  assign loop_nxt = (loop_cnt == '1) ? loop_cnt : (loop_cnt + LOOP_W'(1));
  assign complete = wrap && (loops_r != '0) && ((loop_cnt + LOOP_W'(1)) == loops_r);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      mode_r   <= MODE_SHIFT_R;
      div_r    <= '0;
      tick_cnt <= '0;
      loops_r  <= '0;
      loop_cnt <= '0;
      step     <= 4'd0;
      gap_r    <= 1'b0;
      LED      <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && (cmd.cmd_op == OP_START)) begin
        // START from any state discards whatever sequence was in flight.
        state    <= ST_RUN;
        mode_r   <= start_mode;
        div_r    <= start_div;
        loops_r  <= cmd.cmd_loops;
        tick_cnt <= '0;
        loop_cnt <= '0;
        step     <= 4'd0;
        gap_r    <= 1'b0;
        LED      <= pattern_at(start_mode, 4'd0);
        busy     <= 1'b1;
      end else if (accept && (cmd.cmd_op == OP_STOP)) begin
        state <= ST_IDLE;
        gap_r <= 1'b0;
        LED   <= 8'h00;
        busy  <= 1'b0;
      end else if (accept && (cmd.cmd_op == OP_PAUSE) && (state == ST_RUN)) begin
        // Counters are left untouched on this edge so resume picks up
        // exactly where the pause froze them.
        state <= ST_PAUSE;
      end else if (accept && (cmd.cmd_op == OP_PAUSE) && (state == ST_PAUSE)) begin
        state <= ST_RUN;
      end else if (tick) begin
        tick_cnt <= '0;
        if (complete) begin
          state    <= ST_IDLE;
          step     <= 4'd0;
          gap_r    <= 1'b0;
          loop_cnt <= loop_nxt;
          LED      <= 8'h00;
          busy     <= 1'b0;
          done     <= 1'b1;
        end else begin
          step     <= nxt_step;
          gap_r    <= nxt_gap;
          LED      <= nxt_led;
          loop_cnt <= wrap ? loop_nxt : loop_cnt;
        end
      end else if (state == ST_RUN) begin
        tick_cnt <= tick_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//
// Self-checking bench for led_seq_ctrl. Expected LED/busy/done values per
// clock are generated by a small arithmetic model of the pattern timing,
// pushed into a scoreboard queue when a command is issued, and popped and
// compared one per cycle as the DUT runs. DEF_DIV is overridden to 5 so
// the cmd_div == 0 case finishes quickly.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

  localparam int DIV_W      = 18;
  localparam int LOOP_W     = 8;
  localparam int TB_DEF_DIV = 5;

`ifdef LED_SEQ_GAP_EN
  localparam bit GAP_BENCH = 1'b1;
`else
  localparam bit GAP_BENCH = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] led;
    logic       busy;
    logic       done;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] LED;
  logic       busy;
  logic       done;

  int   check_count;
  int   pass_count;
  exp_t sb_q[$];
  int   stalls;

  led_seq_ctrl_if #(.DIV_W(DIV_W), .LOOP_W(LOOP_W)) cmd_if ();

  led_seq_ctrl #(
    .DIV_W  (DIV_W),
    .LOOP_W (LOOP_W),
    .DEF_DIV(TB_DEF_DIV)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cmd      (cmd_if),
    .LED      (LED),
    .busy     (busy),
    .done     (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, need finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Pattern value at step s, written from the LED pictures rather than
  // from a shift table.
  function automatic logic [7:0] pat(input int mode, input int s);
    logic [7:0] one_hot_hi;
    one_hot_hi = 8'h80;
    case (mode)
      0:       return one_hot_hi >> s;
      1:       return one_hot_hi >> (7 - s);
      2:       return (s == 0) ? 8'hFF : 8'h00;
      default: return (s < 8) ? (one_hot_hi >> s) : (one_hot_hi >> (14 - s));
    endcase
  endfunction

  // Expected outputs k clocks after the START accept edge.
  function automatic exp_t model_at(input int mode, input int div, input int loops, input int k);
    exp_t e;
    int   len;
    int   cyc;
    int   t;
    int   pos;
    bit   gap;
    gap = GAP_BENCH && (mode != 2);
    len = (mode == 2) ? 2 : ((mode == 3) ? 14 : 8);
    cyc = gap ? 2 * len : len;
    t   = k / div;
    e.led  = 8'h00;
    e.busy = 1'b1;
    e.done = 1'b0;
    if ((loops != 0) && (t >= loops * cyc)) begin
      e.busy = 1'b0;
      e.done = (k == loops * cyc * div);
    end else begin
      pos = t % cyc;
      if (gap) e.led = (pos % 2 == 1) ? 8'h00 : pat(mode, pos / 2);
      else     e.led = pat(mode, pos);
    end
    return e;
  endfunction

  task automatic push_run(input int mode, input int div, input int loops,
                          input int k_first, input int n);
    for (int k = k_first; k < k_first + n; k++) sb_q.push_back(model_at(mode, div, loops, k));
  endtask

  task automatic push_const(input logic [7:0] led, input logic b, input int n);
    exp_t e;
    e.led  = led;
    e.busy = b;
    e.done = 1'b0;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // Compare one scoreboard entry per clock, starting at the current
  // sample point.
  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output({tag, "_led"},  LED,  e.led);
      check_output({tag, "_busy"}, busy, e.busy);
      check_output({tag, "_done"}, done, e.done);
      if (sb_q.size() > 0) begin
        @(posedge sys_clk);
        #1;
      end
    end
  endtask

  // Present a command and hold it until it is taken. Returns #1 after the
  // accept edge, with the number of cycles cmd_ready was low.
  task automatic apply_stimulus(input logic [1:0] op, input logic [1:0] mode,
                                input int div, input int loops, output int n_stall);
    bit accepted;
    accepted = 1'b0;
    n_stall  = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_mode  = mode;
    cmd_if.cmd_div   = DIV_W'(div);
    cmd_if.cmd_loops = LOOP_W'(loops);
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge sys_clk);
      if (cmd_if.cmd_ready === 1'b1) accepted = 1'b1;
      else n_stall++;
    end
    check_output("cmd_accept", accepted, 1);
    if (accepted) begin
      @(posedge sys_clk);
      #1;
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
  endtask

  task automatic reset_check(input string tag);
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_output({tag, "_led"},   LED,              8'h00);
    check_output({tag, "_busy"},  busy,             1'b0);
    check_output({tag, "_done"},  done,             1'b0);
    check_output({tag, "_ready"}, cmd_if.cmd_ready, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    check_count      = 0;
    pass_count       = 0;
    sys_rst_n        = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_mode  = 2'd0;
    cmd_if.cmd_div   = '0;
    cmd_if.cmd_loops = '0;

    #12;
    check_output("rst_led",   LED,              8'h00);
    check_output("rst_busy",  busy,             1'b0);
    check_output("rst_done",  done,             1'b0);
    check_output("rst_ready", cmd_if.cmd_ready, 1'b1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    $display("[TB] SHIFT_R div=4 loops=1");
    push_run(0, 4, 1, 0, (GAP_BENCH ? 64 : 32) + 4);
    apply_stimulus(2'd1, 2'd0, 4, 1, stalls);
    drain("shr");

    $display("[TB] BLINK div=2 loops=2");
    push_run(2, 2, 2, 0, 12);
    apply_stimulus(2'd1, 2'd2, 2, 2, stalls);
    drain("blink");

    $display("[TB] SHIFT_R cmd_div=0 uses default divisor");
    push_run(0, TB_DEF_DIV, 1, 0, (GAP_BENCH ? 80 : 40) + 3);
    apply_stimulus(2'd1, 2'd0, 0, 1, stalls);
    drain("defdiv");

    $display("[TB] SHIFT_R div=2 loops=1");
    push_run(0, 2, 1, 0, (GAP_BENCH ? 32 : 16) + 3);
    apply_stimulus(2'd1, 2'd0, 2, 1, stalls);
    drain("shr2");

    $display("[TB] BOUNCE div=1 forever");
    push_run(3, 1, 0, 0, GAP_BENCH ? 60 : 45);
    apply_stimulus(2'd1, 2'd3, 1, 0, stalls);
    drain("bounce");
    reset_check("bounce_rst");

    $display("[TB] reset mid-run SHIFT_R div=4");
    push_run(0, 4, 0, 0, 6);
    apply_stimulus(2'd1, 2'd0, 4, 0, stalls);
    drain("midrun");
    reset_check("midrun_rst");

    $display("[TB] SHIFT_L div=3 pause and resume");
    push_run(1, 3, 0, 0, 1);
    apply_stimulus(2'd1, 2'd1, 3, 0, stalls);
    drain("pause_start");
    @(posedge sys_clk);
    #1;
    apply_stimulus(2'd2, 2'd0, 0, 0, stalls);
    push_const(model_at(1, 3, 0, 0).led, 1'b1, 10);
    drain("paused");
    push_run(1, 3, 0, 1, 3);
    apply_stimulus(2'd2, 2'd0, 0, 0, stalls);
    drain("resume");
    apply_stimulus(2'd3, 2'd0, 0, 0, stalls);
    push_const(8'h00, 1'b0, 3);
    drain("stop_run");

    $display("[TB] command held across a tick, then STOP while paused");
    push_run(0, 2, 0, 0, 1);
    apply_stimulus(2'd1, 2'd0, 2, 0, stalls);
    drain("coll_start");
    @(posedge sys_clk);
    #1;
    apply_stimulus(2'd2, 2'd0, 0, 0, stalls);
    check_output("tick_stall", stalls, 1);
    push_const(model_at(0, 2, 0, 2).led, 1'b1, 6);
    drain("coll_paused");
    apply_stimulus(2'd3, 2'd0, 0, 0, stalls);
    check_output("pause_stall", stalls, 0);
    push_const(8'h00, 1'b0, 4);
    drain("stop_pause");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Command-driven sequencer for the 8-bit board LED bank.
- Accepts start/pause/stop commands from a control master over a valid/ready handshake.
- Runs a programmable step prescaler and drives one of four display patterns for a programmed number of loops, or forever.
- Sits between the board control logic and the LED pins; it is the only driver of LED.

Parameters:
- DIV_W, 18: width of the step prescaler and of cmd_div.
- LOOP_W, 8: width of the loop counter and of cmd_loops.
- DEF_DIV, 100000: divisor used when cmd_div == 0.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  2  0=NOP, 1=START, 2=PAUSE (toggles pause/resume), 3=STOP.
- cmd_mode  in  2  0=SHIFT_R, 1=SHIFT_L, 2=BLINK, 3=BOUNCE; sampled on START only.
- cmd_div  in  DIV_W  clocks per step; sampled on START only.
- cmd_loops  in  LOOP_W  pattern cycles to run, 0 = infinite; sampled on START only.
- LED  out  8  LED drive, 1 = lit.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse when the programmed loops complete.

Behaviour:
- Reset (asynchronous, sys_rst_n low): state=IDLE, LED=8'h00, busy=0, done=0, cmd_ready=1, all counters 0.
- A command is accepted on a rising edge where cmd_valid && cmd_ready are both high. NOP is accepted and has no effect.
- cmd_ready=1 in IDLE and PAUSE. In RUN, cmd_ready=0 on the cycle a step tick fires; the step has priority and the master must hold the command.
- Divisor: div_r <= (cmd_div==0) ? DEF_DIV : cmd_div. Truncate DEF_DIV to DIV_W bits.
- Prescaler: tick_cnt counts 0..div_r-1 in RUN only. A tick is the cycle where tick_cnt==div_r-1; tick_cnt wraps to 0. div_r==1 gives a tick every cycle.
- States: IDLE, RUN, PAUSE. busy is registered, equal to (state != IDLE).
- START (any state):
  - load mode, div_r and loops; tick_cnt=0; step=0; loop_cnt=0.
  - LED <= initial pattern on the accept edge; state=RUN.
  - Restarting mid-run discards the current sequence.
- PAUSE: RUN->PAUSE freezes LED, tick_cnt, step and loop_cnt. PAUSE->RUN resumes counting from the frozen tick_cnt. Ignored in IDLE.
- STOP: from any state, go to IDLE and set LED <= 8'h00. No done pulse.
- Patterns (LED value at step s; cycle length L):
  - SHIFT_R, L=8: 8'h80 >> s.
  - SHIFT_L, L=8: 8'h01 << s.
  - BLINK, L=2: s=0 -> 8'hFF, s=1 -> 8'h00.
  - BOUNCE, L=14: s=0..7 -> 8'h80>>s; s=8..13 -> 8'h01<<(s-7), i.e. 02,04,...,40.
- On each tick: step <= (step==L-1) ? 0 : step+1, and LED <= pattern(next step). Wrap-around completes one loop and increments loop_cnt.
- Completion: cmd_loops != 0 and a wrap makes loop_cnt reach cmd_loops. On that edge: state=IDLE, LED=8'h00, done=1 for exactly one cycle. The initial pattern is not redisplayed.
- loops==0: loop_cnt saturates and never terminates the sequence.
- First LED change occurs exactly div_r clocks after the START accept edge.

Optional Feature:
- Macro: LED_SEQ_GAP_EN.
- With LED_SEQ_GAP_EN defined:
  - each step is followed by one dark sub-step of equal duration (LED=8'h00);
  - effective cycle length is 2L ticks;
  - a wrap is counted only after the gap of step L-1;
  - BLINK is unaffected (already alternating).
- Without the macro: no gap sub-steps; behaviour exactly as above.

Test Plan:
- Reset mid-RUN (SHIFT_R, div=4) -> LED=00, busy=0, done=0 immediately, asynchronously; cmd_ready=1.
- START SHIFT_R, div=4, loops=1 -> LED 80 at accept edge; 40 at +4 clks; …; 01 at +28; at +32 LED=00, done=1 for 1 cycle, busy=0.
- START BOUNCE, div=1, loops=0 -> LED sequence 80,40,…,01,02,…,40,80 repeating every 14 clks, never done.
- START SHIFT_L, div=3 -> at tick_cnt=1 send PAUSE, hold 10 clks, then PAUSE -> LED frozen at 01 during pause; changes to 02 exactly 2 clks after resume accept.
- Command held valid on a tick cycle (div=2, RUN) -> cmd_ready=0 that cycle; command accepted next cycle; no command lost or duplicated. STOP during PAUSE -> LED=00, no done.
- START with cmd_div=0 -> first step change after DEF_DIV clks (use DEF_DIV=5 override); with LED_SEQ_GAP_EN, SHIFT_R div=2 -> 80,00,40,00,… each held 2 clks.
